// File: rtl/dense_layer.sv
// dense_layer: time-multiplexed fully-connected layer, z = W*x + b, signed
// fixed point (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS). One weight row is fetched
// per cycle from an external synchronous ROM. All NUM_NODES MACs run in
// parallel on that row.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous, active-low reset
//   i_valid      input vector valid
//   i_ready      block can accept a vector (IDLE)
//   xin          NUM_INPUTS x DATA_WIDTH activation vector
//   b            NUM_NODES x DATA_WIDTH bias vector, static while busy
//   w_en         ROM read enable
//   w_addr       ROM row address (input index k), 0 when w_en=0
//   w_data       NUM_NODES x DATA_WIDTH weight row, valid 1 cycle after w_en
//   o_valid      one-cycle pulse, zout holds a new result
//   zout         NUM_NODES x DATA_WIDTH registered, saturated result
//   dbg_state_o  current FSM state (0=IDLE, 1=RUN, 2=LAST)
//
// Handshake: a vector transfers on a posedge where i_valid=1 and i_ready=1.
// i_ready is high only in IDLE; i_valid is ignored otherwise (no queuing).
// o_valid is a single-cycle pulse with no back-pressure.
module dense_layer #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int NUM_INPUTS = 20,
   parameter int NUM_NODES  = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_valid,
   output logic                                  i_ready,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] xin,
   input  logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  b,
   output logic                                  w_en,
   output logic [$clog2(NUM_INPUTS)-1:0]         w_addr,
   input  logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  w_data,
   output logic                                  o_valid,
   output logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  zout,
   output logic [1:0]                            dbg_state_o
);

   localparam int CW = $clog2(NUM_INPUTS);
   localparam int PW = 2 * DATA_WIDTH;
   // Wide enough that NUM_INPUTS full-scale products plus the bias never overflow.
   localparam int AW = PW + CW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_e;

   state_e                                state_q;
   logic [CW-1:0]                         cnt_q;
   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_q;
   logic signed [AW-1:0]                  acc_q [NUM_NODES];
   logic                                  o_valid_q;
   logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  zout_q;

   logic [CW-1:0]                         k_idx;
   logic signed [DATA_WIDTH-1:0]          x_k;
   logic                                  acc_en;
   logic signed [PW-1:0]                  prod  [NUM_NODES];
   logic signed [AW-1:0]                  acc_d [NUM_NODES];
   logic signed [AW-1:0]                  shr   [NUM_NODES];
   logic [NUM_NODES-1:0][DATA_WIDTH-1:0]  sat_d;

   // w_data always carries the row addressed in the previous cycle, so the
   // activation used is x[cnt-1] in RUN and the final x in LAST. The first
   // RUN cycle has no row returned yet and accumulates nothing.
   always_comb begin
      k_idx  = (state_q == LAST) ? CW'(NUM_INPUTS - 1) : (cnt_q - CW'(1));
      x_k    = $signed(x_q[k_idx]);
      acc_en = (state_q == LAST) || ((state_q == RUN) && (cnt_q != '0));
      for (int n = 0; n < NUM_NODES; n++) begin
         prod[n]  = x_k * $signed(w_data[n]);
         acc_d[n] = acc_q[n] + {{(AW - PW){prod[n][PW-1]}}, prod[n]};
         shr[n]   = acc_d[n] >>> FRAC_BITS;
         // Fits in DATA_WIDTH when every bit above the result sign matches it.
         if ((&shr[n][AW-1:DATA_WIDTH-1]) || (~|shr[n][AW-1:DATA_WIDTH-1])) begin
            sat_d[n] = shr[n][DATA_WIDTH-1:0];
         end else if (shr[n][AW-1]) begin
            sat_d[n] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            sat_d[n] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         x_q       <= '0;
         o_valid_q <= 1'b0;
         zout_q    <= '0;
         for (int n = 0; n < NUM_NODES; n++) begin
            acc_q[n] <= '0;
         end
      end else begin
         o_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  x_q   <= xin;
                  cnt_q <= '0;
                  // Bias is aligned to the product scale (2*FRAC_BITS fraction bits).
                  for (int n = 0; n < NUM_NODES; n++) begin
                     acc_q[n] <= {{(AW - DATA_WIDTH){b[n][DATA_WIDTH-1]}}, b[n]} <<< FRAC_BITS;
                  end
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (acc_en) begin
                  for (int n = 0; n < NUM_NODES; n++) begin
                     acc_q[n] <= acc_d[n];
                  end
               end
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(NUM_INPUTS - 1)) begin
                  state_q <= LAST;
               end
            end
            LAST: begin
               for (int n = 0; n < NUM_NODES; n++) begin
                  acc_q[n] <= acc_d[n];
               end
               zout_q    <= sat_d;
               o_valid_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_ready     = (state_q == IDLE);
   assign w_en        = (state_q == RUN);
   assign w_addr      = w_en ? cnt_q : '0;
   assign o_valid     = o_valid_q;
   assign zout        = zout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: directed bench for dense_layer at default parameters.
// A behavioural synchronous ROM answers w_en/w_addr. Expected results are
// hand-computed Q16.16 constants queued in exp_q and compared whenever
// o_valid pulses.
module tb_dense_layer;

   localparam int DW  = 32;
   localparam int FB  = 16;
   localparam int NI  = 20;
   localparam int NN  = 10;
   localparam int AWD = $clog2(NI);

   localparam logic [DW-1:0] ONE  = 32'h0001_0000;
   localparam logic [DW-1:0] HALF = 32'h0000_8000;
   localparam logic [DW-1:0] JUNK = 32'h7FFF_FFFF;

   logic                  clk;
   logic                  rst;
   logic                  i_valid;
   logic                  i_ready;
   logic [NI-1:0][DW-1:0] xin;
   logic [NN-1:0][DW-1:0] b;
   logic                  w_en;
   logic [AWD-1:0]        w_addr;
   logic [NN-1:0][DW-1:0] w_data;
   logic                  o_valid;
   logic [NN-1:0][DW-1:0] zout;
   logic [1:0]            dbg_state;

   logic [NN-1:0][DW-1:0] rom [NI];
   logic [DW-1:0]         exp_q[$];
   int                    addr_log[$];
   int                    n_vec;
   int                    n_err;

   dense_layer #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .NUM_INPUTS (NI),
      .NUM_NODES  (NN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .xin         (xin),
      .b           (b),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .o_valid     (o_valid),
      .zout        (zout),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: row valid one cycle after the read.
   always @(posedge clk) begin
      if (w_en) w_data <= rom[w_addr];
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (w_en) addr_log.push_back(int'(w_addr));
         else check("w_addr_idle", 64'(w_addr), 64'd0);
         if (o_valid) begin
            check("exp_avail", 64'(exp_q.size() >= NN), 64'd1);
            if (exp_q.size() >= NN) begin
               for (int n = 0; n < NN; n++) begin
                  check($sformatf("zout[%0d]", n), 64'(zout[n]), 64'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_x(input logic [DW-1:0] v);
      for (int i = 0; i < NI; i++) xin[i] = v;
   endtask

   task automatic set_w(input logic [DW-1:0] v);
      for (int i = 0; i < NI; i++)
         for (int n = 0; n < NN; n++) rom[i][n] = v;
   endtask

   task automatic set_b(input logic [DW-1:0] v);
      for (int n = 0; n < NN; n++) b[n] = v;
   endtask

   task automatic set_b_ramp();
      for (int n = 0; n < NN; n++) b[n] = 32'(n * 65536);
   endtask

   task automatic push_all(input logic [DW-1:0] v);
      for (int n = 0; n < NN; n++) exp_q.push_back(v);
   endtask

   task automatic push_ramp_minus20();
      for (int n = 0; n < NN; n++) exp_q.push_back(32'((n - 20) * 65536));
   endtask

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!i_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("ready_wait", 64'(i_ready), 64'd1);
   endtask

   // Called just after an acceptance edge (edge 0). Cycle k is the edge
   // acceptance+k; o_valid seen before edge k gives lat=k. On edges d1/d2 a
   // junk vector is offered, which must be refused. Returns at the negedge
   // where o_valid was seen.
   task automatic wait_result(input int d1, input int d2, output int lat);
      bit drove;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         drove = 1'b0;
         if (k == d1 || k == d2) begin
            i_valid = 1'b1;
            set_x(JUNK);
            drove = 1'b1;
            check($sformatf("busy_ready_k%0d", k), 64'(i_ready), 64'd0);
         end
         @(negedge clk);
         if (o_valid) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
         if (drove) i_valid = 1'b0;
      end
   endtask

   task automatic check_addrs();
      check("addr_count", 64'(addr_log.size()), 64'(NI));
      for (int i = 0; i < addr_log.size(); i++) check($sformatf("addr_seq[%0d]", i), 64'(addr_log[i]), 64'(i));
      addr_log.delete();
   endtask

   task automatic run_vec(input int d1, input int d2);
      int lat;
      addr_log.delete();
      wait_ready();
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      wait_result(d1, d2, lat);
      check("latency", 64'(lat), 64'd22);
      @(posedge clk); #1;
      @(negedge clk);
      check("o_valid_pulse", 64'(o_valid), 64'd0);
      check_addrs();
      @(posedge clk); #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b0;
      i_valid = 1'b0;
      xin     = '0;
      b       = '0;
      set_w(HALF);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Reset state
      check("rst_i_ready", 64'(i_ready), 64'd1);
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_w_en", 64'(w_en), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      for (int n = 0; n < NN; n++) check($sformatf("rst_zout[%0d]", n), 64'(zout[n]), 64'd0);

      // T1: 20 * (1.0 * 0.5) = 10.0
      set_x(ONE); set_w(HALF); set_b(32'h0);
      push_all(32'h000A_0000);
      run_vec(0, 0);

      // T2: 20 * (1.0 * -1.0) + n = n - 20
      set_x(ONE); set_w(32'hFFFF_0000); set_b_ramp();
      push_ramp_minus20();
      run_vec(0, 0);

      // T3: positive and negative saturation
      set_x(JUNK); set_w(JUNK); set_b(JUNK);
      push_all(32'h7FFF_FFFF);
      run_vec(0, 0);
      set_x(JUNK); set_w(32'h8000_0000); set_b(32'h0);
      push_all(32'h8000_0000);
      run_vec(0, 0);

      // T4: 20 * (2.0 * 0.5) = 20.0; offers on edges +3 and +21 are ignored
      set_x(32'h0002_0000); set_w(HALF); set_b(32'h0);
      push_all(32'h0014_0000);
      run_vec(3, 21);

      // T5: back-to-back, A = 1.0 -> 10.0, B = 3.0 -> 30.0
      set_x(ONE); set_w(HALF); set_b(32'h0);
      push_all(32'h000A_0000);
      push_all(32'h001E_0000);
      addr_log.delete();
      wait_ready();
      i_valid = 1'b1;
      @(posedge clk); #1;
      set_x(32'h0003_0000);
      wait_result(0, 0, lat);
      check("b2b_latency_a", 64'(lat), 64'd22);
      check("b2b_ready", 64'(i_ready), 64'd1);
      check_addrs();
      @(posedge clk); #1;
      i_valid = 1'b0;
      check("b2b_busy", 64'(i_ready), 64'd0);
      wait_result(0, 0, lat);
      check("b2b_latency_b", 64'(lat), 64'd22);
      @(posedge clk); #1;
      check_addrs();

      // T6: reset at acceptance+10 aborts the run; nothing is expected from it
      set_x(ONE); set_w(HALF); set_b(32'h0);
      wait_ready();
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("mid_rst_o_valid", 64'(o_valid), 64'd0);
      check("mid_rst_i_ready", 64'(i_ready), 64'd1);
      check("mid_rst_w_en", 64'(w_en), 64'd0);
      for (int n = 0; n < NN; n++) check($sformatf("mid_rst_zout[%0d]", n), 64'(zout[n]), 64'd0);
      addr_log.delete();
      set_x(ONE); set_w(32'hFFFF_0000); set_b_ramp();
      push_ramp_minus20();
      run_vec(0, 0);

      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
